// File: rtl/handshake_rr_arbiter_pkg.sv
// ============================================================================
// Module   : handshake_rr_arbiter_pkg
// Brief    : Shared index-width helper for the round-robin handshake arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package handshake_rr_arbiter_pkg;

  // Channel index width; a single channel still needs one bit of index.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/handshake_rr_arbiter_picker.sv
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin pick, first request after 'last'.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker
  import handshake_rr_arbiter_pkg::*;
#(
  parameter  int SIZE  = 2,
  localparam int IDX_W = idx_width(SIZE)
) (
  input  logic [SIZE-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [SIZE-1:0]  grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [SIZE-1:0]   w_mask;
  logic [2*SIZE-1:0] w_dbl;
  int                w_pos;
  int                w_idx;

  // Lower copy holds only requests above 'last'; the upper copy supplies the
  // wrap-around, so the lowest set bit of the doubled vector is the winner.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < SIZE; j++) begin
      w_mask[j] = (j > int'(last));
    end
    w_dbl = {req, req & w_mask};
    w_pos = 0;
    for (int j = 2*SIZE-1; j >= 0; j--) begin
      if (w_dbl[j]) w_pos = j;
    end
    w_idx = (w_pos >= SIZE) ? (w_pos - SIZE) : w_pos;
  end

  assign any       = |req;
  assign grant_idx = IDX_W'(w_idx);

  always_comb begin
    grant_onehot = '0;
    for (int j = 0; j < SIZE; j++) begin
      grant_onehot[j] = any && (j == w_idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/handshake_rr_arbiter.sv
// ============================================================================
// Module   : handshake_rr_arbiter
// Brief    : Round-robin arbiter feeding a one-slot registered output buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module handshake_rr_arbiter
  import handshake_rr_arbiter_pkg::*;
#(
  parameter  int SIZE      = 2,
  parameter  int DATA_TYPE = 32,
  localparam int IDX_W     = idx_width(SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic                      outs_valid,
  input  logic                      outs_ready,
  output logic [IDX_W-1:0]          index
);

  logic [IDX_W-1:0]     r_last;
  logic [DATA_TYPE-1:0] r_outs;
  logic                 r_outs_valid;
  logic [IDX_W-1:0]     r_index;

  logic [SIZE-1:0]      w_grant_onehot;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_any;
  logic                 w_can_accept;
  logic                 w_xfer;
  logic [DATA_TYPE-1:0] w_data;

  rr_priority_picker #(
    .SIZE (SIZE)
  ) u_picker (
    .req          (ins_valid),
    .last         (r_last),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  // Readiness is suppressed while reset is held so no token slips in.
  assign w_can_accept = !r_outs_valid || outs_ready;
  assign w_xfer       = rst && w_can_accept && w_any;
  assign ins_ready    = w_xfer ? w_grant_onehot : '0;

  always_comb begin
    w_data = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (w_grant_onehot[j]) w_data = ins[j*DATA_TYPE +: DATA_TYPE];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last       <= IDX_W'(SIZE - 1);
      r_outs       <= '0;
      r_outs_valid <= 1'b0;
      r_index      <= '0;
    end else if (w_xfer) begin
      r_last       <= w_grant_idx;
      r_outs       <= w_data;
      r_outs_valid <= 1'b1;
      r_index      <= w_grant_idx;
    end else if (outs_ready) begin
      r_outs_valid <= 1'b0;
    end
  end

  assign outs       = r_outs;
  assign outs_valid = r_outs_valid;
  assign index      = r_index;

endmodule

`default_nettype wire

// File: tb/tb_handshake_rr_arbiter.sv
// ============================================================================
// Module   : tb_handshake_rr_arbiter
// Brief    : Directed self-checking bench for the round-robin handshake arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_handshake_rr_arbiter;

  localparam int SIZE      = 4;
  localparam int DATA_TYPE = 32;
  localparam int IDX_W     = 2;

  logic                      clk;
  logic                      rst;
  logic [SIZE*DATA_TYPE-1:0] ins;
  logic [SIZE-1:0]           ins_valid;
  logic [SIZE-1:0]           ins_ready;
  logic [DATA_TYPE-1:0]      outs;
  logic                      outs_valid;
  logic                      outs_ready;
  logic [IDX_W-1:0]          index;

  int checks = 0;
  int errors = 0;

  handshake_rr_arbiter #(
    .SIZE      (SIZE),
    .DATA_TYPE (DATA_TYPE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .index      (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DATA_TYPE-1:0] d);
    ins[ch*DATA_TYPE +: DATA_TYPE] = d;
  endtask

  initial begin
    rst        = 1'b0;
    outs_ready = 1'b1;
    ins_valid  = 4'b1111;
    for (int i = 0; i < SIZE; i++) set_data(i, 32'h1000_0000 + i);

    // Reset held with every channel requesting.
    tick();
    tick();
    chk("rst_valid", outs_valid, 0);
    chk("rst_ready", ins_ready, 0);
    chk("rst_index", index, 0);
    chk("rst_outs", outs, 0);

    // All valid, downstream always ready: index rotates 0,1,2,3,...
    rst = 1'b1;
    #1;
    chk("rr_first_ready", ins_ready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid", outs_valid, 1);
      chk("rr_index", index, k % 4);
      chk("rr_data", outs, 32'h1000_0000 + (k % 4));
      chk("rr_next_ready", ins_ready, 4'b0001 << ((k + 1) % 4));
    end

    ins_valid = 4'b0000;
    tick();
    chk("idle_valid", outs_valid, 0);
    chk("idle_ready", ins_ready, 0);

    // Single channel 2 request against a stalled slot.
    outs_ready = 1'b0;
    set_data(2, 32'hA5A5_A5A5);
    ins_valid = 4'b0100;
    #1;
    chk("c2_ready", ins_ready, 4'b0100);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("c2_stall_valid", outs_valid, 1);
      chk("c2_stall_outs", outs, 32'hA5A5_A5A5);
      chk("c2_stall_index", index, 2);
      chk("c2_stall_ready", ins_ready, 0);
      tick();
    end
    ins_valid  = 4'b0000;
    outs_ready = 1'b1;
    tick();
    chk("c2_drain_valid", outs_valid, 0);
    chk("c2_hold_outs", outs, 32'hA5A5_A5A5);
    chk("c2_hold_index", index, 2);

    // Channel 1 granted, then stalled while 0 and 3 wait; pointer must stay at 1.
    outs_ready = 1'b0;
    set_data(1, 32'h1111_0001);
    ins_valid = 4'b0010;
    tick();
    chk("c1_index", index, 1);
    ins_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("c1_stall_ready", ins_ready, 0);
      chk("c1_stall_index", index, 1);
      chk("c1_stall_outs", outs, 32'h1111_0001);
    end
    outs_ready = 1'b1;
    #1;
    chk("rel_ready3", ins_ready, 4'b1000);
    tick();
    chk("rel_index3", index, 3);
    chk("rel_outs3", outs, 32'h1000_0003);
    ins_valid = 4'b0001;
    #1;
    chk("rel_ready0", ins_ready, 4'b0001);
    tick();
    chk("rel_index0", index, 0);
    chk("rel_valid0", outs_valid, 1);

    // Drain and accept in the same cycle keeps the slot full with new data.
    set_data(0, 32'hDEAD_BEEF);
    #1;
    chk("da_ready", ins_ready, 4'b0001);
    tick();
    chk("da_valid", outs_valid, 1);
    chk("da_outs", outs, 32'hDEAD_BEEF);
    chk("da_index", index, 0);

    // Reset pulse with a buffered token; readiness blocked during reset.
    ins_valid = 4'b1111;
    rst = 1'b0;
    #1;
    chk("rp_ready", ins_ready, 0);
    tick();
    chk("rp_valid", outs_valid, 0);
    chk("rp_outs", outs, 0);
    chk("rp_index", index, 0);
    rst = 1'b1;
    #1;
    chk("rp_next_ready", ins_ready, 4'b0001);
    tick();
    chk("rp_next_index", index, 0);
    chk("rp_next_outs", outs, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
